// File: rtl/reorder_buffer_pkg.sv
// Shared types and instruction-id constants for the reorder buffer slice.
// Id classification helpers keep the commit and allocate logic readable.
package reorder_buffer_pkg;

  localparam int INSTR_ID_WIDTH = 6;
  localparam int REG_IDX_WIDTH  = 5;

  typedef logic [INSTR_ID_WIDTH-1:0] instr_id_t;
  typedef logic [REG_IDX_WIDTH-1:0]  reg_idx_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam reg_idx_t REG_ZERO = 5'd0;

  localparam instr_id_t ID_JAL  = 6'd3;
  localparam instr_id_t ID_JALR = 6'd4;
  localparam instr_id_t ID_BEQ  = 6'd5;
  localparam instr_id_t ID_BGEU = 6'd10;
  localparam instr_id_t ID_LHU  = 6'd15;
  localparam instr_id_t ID_SB   = 6'd16;
  localparam instr_id_t ID_SW   = 6'd18;
  localparam instr_id_t ID_ADDI = 6'd19;

  typedef struct packed {
    logic      busy;
    logic      ready;
    logic      pred;
    logic      taken;
    instr_id_t id;
    reg_idx_t  rd;
  } rob_ctrl_t;

  function automatic logic is_store(instr_id_t id);
    return (id >= ID_SB) && (id <= ID_SW);
  endfunction

  function automatic logic is_branch(instr_id_t id);
    return (id >= ID_BEQ) && (id <= ID_BGEU);
  endfunction

  function automatic logic is_jalr(instr_id_t id);
    return id == ID_JALR;
  endfunction

endpackage

// File: rtl/rob_query_port.sv
// Single operand lookup into the ROB result state.
// With ROB_CDB_BYPASS_EN defined, a same-cycle CDB hit also counts as ready (ALU first).
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_IDX_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ROB_IDX_WIDTH-1:0]                          idx_i,
  input  logic [(1<<ROB_IDX_WIDTH)-1:0]                     busy_i,
  input  logic [(1<<ROB_IDX_WIDTH)-1:0]                     ready_i,
  input  logic [(1<<ROB_IDX_WIDTH)-1:0][DATA_WIDTH-1:0]     val_i,
  input  logic                                              alu_en_i,
  input  logic [ROB_IDX_WIDTH-1:0]                          alu_idx_i,
  input  logic [DATA_WIDTH-1:0]                             alu_val_i,
  input  logic                                              lsb_en_i,
  input  logic [ROB_IDX_WIDTH-1:0]                          lsb_idx_i,
  input  logic [DATA_WIDTH-1:0]                             lsb_val_i,
  output logic                                              ready_o,
  output logic [DATA_WIDTH-1:0]                             val_o
);

  logic stored_ready_s;
  assign stored_ready_s = busy_i[idx_i] && ready_i[idx_i];

`ifdef ROB_CDB_BYPASS_EN
  logic hit_alu_s;
  logic hit_lsb_s;
  assign hit_alu_s = busy_i[idx_i] && alu_en_i && (alu_idx_i == idx_i);
  assign hit_lsb_s = busy_i[idx_i] && lsb_en_i && (lsb_idx_i == idx_i);
  assign ready_o   = stored_ready_s || hit_alu_s || hit_lsb_s;
  assign val_o     = hit_alu_s ? alu_val_i : (hit_lsb_s ? lsb_val_i : val_i[idx_i]);
`else
  logic unused_cdb_s;
  assign unused_cdb_s = ^{alu_en_i, alu_idx_i, alu_val_i, lsb_en_i, lsb_idx_i, lsb_val_i, TRUE};
  assign ready_o      = stored_ready_s;
  assign val_o        = val_i[idx_i];
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, CDB writeback, commit at head, mispredict flush.
// Optional same-cycle CDB bypass on the query ports is enabled by defining ROB_CDB_BYPASS_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_IDX_WIDTH = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      issue_en_in,
  input  logic [INSTR_ID_WIDTH-1:0] issue_instr_id_in,
  input  logic [REG_IDX_WIDTH-1:0]  issue_rd_in,
  input  logic [DATA_WIDTH-1:0]     issue_pc_in,
  input  logic                      issue_pred_taken_in,
  output logic                      rob_empty_out,
  output logic [ROB_IDX_WIDTH-1:0]  rob_head_out,
  output logic [ROB_IDX_WIDTH-1:0]  rob_tail_out,
  input  logic                      alu_cdb_en_in,
  input  logic [ROB_IDX_WIDTH-1:0]  alu_cdb_idx_in,
  input  logic [DATA_WIDTH-1:0]     alu_cdb_val_in,
  input  logic                      alu_cdb_taken_in,
  input  logic [DATA_WIDTH-1:0]     alu_cdb_target_in,
  input  logic                      lsb_cdb_en_in,
  input  logic [ROB_IDX_WIDTH-1:0]  lsb_cdb_idx_in,
  input  logic [DATA_WIDTH-1:0]     lsb_cdb_val_in,
  input  logic [ROB_IDX_WIDTH-1:0]  qry1_idx_in,
  input  logic [ROB_IDX_WIDTH-1:0]  qry2_idx_in,
  output logic                      qry1_ready_out,
  output logic                      qry2_ready_out,
  output logic [DATA_WIDTH-1:0]     qry1_val_out,
  output logic [DATA_WIDTH-1:0]     qry2_val_out,
  output logic                      commit_reg_en_out,
  output logic [REG_IDX_WIDTH-1:0]  commit_rd_out,
  output logic [DATA_WIDTH-1:0]     commit_val_out,
  output logic [ROB_IDX_WIDTH-1:0]  commit_idx_out,
  output logic                      commit_store_en_out,
  output logic                      flush_out,
  output logic [DATA_WIDTH-1:0]     flush_pc_out
);

  localparam int DEPTH = 1 << ROB_IDX_WIDTH;
  localparam logic [ROB_IDX_WIDTH-1:0] IDX_ZERO = {ROB_IDX_WIDTH{1'b0}};
  localparam logic [ROB_IDX_WIDTH-1:0] IDX_ONE  = {{(ROB_IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [ROB_IDX_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                     empty_q, empty_d;
  rob_ctrl_t [DEPTH-1:0]    ctrl_q, ctrl_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] val_q, val_d, target_q, target_d, pc_q, pc_d;

  logic                     c_reg_en_q, c_reg_en_d, c_store_en_q, c_store_en_d;
  logic [REG_IDX_WIDTH-1:0] c_rd_q, c_rd_d;
  logic [DATA_WIDTH-1:0]    c_val_q, c_val_d, flush_pc_q, flush_pc_d;
  logic [ROB_IDX_WIDTH-1:0] c_idx_q, c_idx_d;
  logic                     flush_q, flush_d;

  logic [DEPTH-1:0] busy_s, ready_s;
  rob_ctrl_t        head_s;
  logic             full_s, issue_acc_s, commit_fire_s;
  reg_idx_t         alloc_rd_s;

  assign head_s        = ctrl_q[head_q];
  assign full_s        = (head_q == tail_q) && !empty_q;
  assign issue_acc_s   = issue_en_in && !full_s;
  assign commit_fire_s = !empty_q && head_s.ready;
  assign alloc_rd_s    = (is_store(issue_instr_id_in) || is_branch(issue_instr_id_in))
                         ? REG_ZERO : issue_rd_in;

  // Flatten busy/ready bits for the query ports.
  always_comb begin
    busy_s  = {DEPTH{1'b0}};
    ready_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      busy_s[i]  = ctrl_q[i].busy;
      ready_s[i] = ctrl_q[i].ready;
    end
  end

  // Next-state: flush clear, writeback, commit decision, allocation and empty tracking.
  always_comb begin
    head_d = head_q; tail_d = tail_q; empty_d = empty_q;
    ctrl_d = ctrl_q; val_d = val_q; target_d = target_q; pc_d = pc_q;
    c_reg_en_d = FALSE; c_store_en_d = FALSE; c_rd_d = REG_ZERO;
    c_val_d = DATA_ZERO; c_idx_d = IDX_ZERO; flush_d = FALSE; flush_pc_d = DATA_ZERO;
    // A decided flush completes even if rdy_in drops, otherwise the redirect would be lost.
    if (flush_q) begin
      head_d = IDX_ZERO; tail_d = IDX_ZERO; empty_d = TRUE;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_d[i].busy  = FALSE;
        ctrl_d[i].ready = FALSE;
      end
    end else if (rdy_in) begin
      if (lsb_cdb_en_in && ctrl_q[lsb_cdb_idx_in].busy) begin
        ctrl_d[lsb_cdb_idx_in].ready = TRUE;
        val_d[lsb_cdb_idx_in]        = lsb_cdb_val_in;
      end else begin
        val_d[lsb_cdb_idx_in] = val_q[lsb_cdb_idx_in];
      end
      if (alu_cdb_en_in && ctrl_q[alu_cdb_idx_in].busy) begin
        ctrl_d[alu_cdb_idx_in].ready = TRUE;
        ctrl_d[alu_cdb_idx_in].taken = alu_cdb_taken_in;
        val_d[alu_cdb_idx_in]        = alu_cdb_val_in;
        target_d[alu_cdb_idx_in]     = alu_cdb_target_in;
      end else begin
        target_d[alu_cdb_idx_in] = target_q[alu_cdb_idx_in];
      end
      if (commit_fire_s) begin
        c_idx_d      = head_q;
        c_rd_d       = head_s.rd;
        c_val_d      = val_q[head_q];
        c_reg_en_d   = (head_s.rd != REG_ZERO);
        c_store_en_d = is_store(head_s.id);
        if (is_jalr(head_s.id) || (is_branch(head_s.id) && (head_s.taken != head_s.pred))) begin
          flush_d    = TRUE;
          flush_pc_d = target_q[head_q];
        end else begin
          flush_d = FALSE;
        end
        ctrl_d[head_q].busy  = FALSE;
        ctrl_d[head_q].ready = FALSE;
        head_d = head_q + IDX_ONE;
      end else begin
        head_d = head_q;
      end
      if (issue_acc_s) begin
        ctrl_d[tail_q].busy  = TRUE;
        ctrl_d[tail_q].ready = FALSE;
        ctrl_d[tail_q].pred  = issue_pred_taken_in;
        ctrl_d[tail_q].taken = FALSE;
        ctrl_d[tail_q].id    = issue_instr_id_in;
        ctrl_d[tail_q].rd    = alloc_rd_s;
        val_d[tail_q]        = DATA_ZERO;
        target_d[tail_q]     = DATA_ZERO;
        pc_d[tail_q]         = issue_pc_in;
        tail_d = tail_q + IDX_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (issue_acc_s) begin
        empty_d = FALSE;
      end else if (commit_fire_s && ((head_q + IDX_ONE) == tail_q)) begin
        empty_d = TRUE;
      end else begin
        empty_d = empty_q;
      end
    end else begin
      empty_d = empty_q;
    end
  end

  // State and registered commit/flush outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= IDX_ZERO;
      tail_q       <= IDX_ZERO;
      empty_q      <= TRUE;
      ctrl_q       <= {(DEPTH*$bits(rob_ctrl_t)){1'b0}};
      val_q        <= {(DEPTH*DATA_WIDTH){1'b0}};
      target_q     <= {(DEPTH*DATA_WIDTH){1'b0}};
      pc_q         <= {(DEPTH*DATA_WIDTH){1'b0}};
      c_reg_en_q   <= FALSE;
      c_store_en_q <= FALSE;
      c_rd_q       <= REG_ZERO;
      c_val_q      <= DATA_ZERO;
      c_idx_q      <= IDX_ZERO;
      flush_q      <= FALSE;
      flush_pc_q   <= DATA_ZERO;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      empty_q      <= empty_d;
      ctrl_q       <= ctrl_d;
      val_q        <= val_d;
      target_q     <= target_d;
      pc_q         <= pc_d;
      c_reg_en_q   <= c_reg_en_d;
      c_store_en_q <= c_store_en_d;
      c_rd_q       <= c_rd_d;
      c_val_q      <= c_val_d;
      c_idx_q      <= c_idx_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
    end
  end

  assign rob_empty_out       = empty_q;
  assign rob_head_out        = head_q;
  assign rob_tail_out        = tail_q;
  assign commit_reg_en_out   = c_reg_en_q;
  assign commit_store_en_out = c_store_en_q;
  assign commit_rd_out       = c_rd_q;
  assign commit_val_out      = c_val_q;
  assign commit_idx_out      = c_idx_q;
  assign flush_out           = flush_q;
  assign flush_pc_out        = flush_pc_q;

  rob_query_port #(.ROB_IDX_WIDTH(ROB_IDX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_qry1 (
    .idx_i(qry1_idx_in), .busy_i(busy_s), .ready_i(ready_s), .val_i(val_q),
    .alu_en_i(alu_cdb_en_in), .alu_idx_i(alu_cdb_idx_in), .alu_val_i(alu_cdb_val_in),
    .lsb_en_i(lsb_cdb_en_in), .lsb_idx_i(lsb_cdb_idx_in), .lsb_val_i(lsb_cdb_val_in),
    .ready_o(qry1_ready_out), .val_o(qry1_val_out)
  );

  rob_query_port #(.ROB_IDX_WIDTH(ROB_IDX_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_qry2 (
    .idx_i(qry2_idx_in), .busy_i(busy_s), .ready_i(ready_s), .val_i(val_q),
    .alu_en_i(alu_cdb_en_in), .alu_idx_i(alu_cdb_idx_in), .alu_val_i(alu_cdb_val_in),
    .lsb_en_i(lsb_cdb_en_in), .lsb_idx_i(lsb_cdb_idx_in), .lsb_val_i(lsb_cdb_val_in),
    .ready_o(qry2_ready_out), .val_o(qry2_val_out)
  );

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) that accepts entries from the Issue stage.
- Collects results broadcast by the ALU/RS and LSB common data buses, and commits in program order to the register file and LSB.
- Raises a flush on a branch mispredict.
- Exports head, tail and empty so Issue can compute free space and the allocated slot (the allocated slot is the tail).

Parameters:
ROB_IDX_WIDTH, 4, entry index width; depth = 2**ROB_IDX_WIDTH (16)
DATA_WIDTH, 32, result/PC width

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; when low, all state holds and no pulse outputs assert
issue_en_in  input  1  allocate entry at tail this cycle
issue_instr_id_in  input  `InstrIdWidth  decoded instruction id
issue_rd_in  input  `RegIdxWidth  destination register (0 = none)
issue_pc_in  input  DATA_WIDTH  instruction PC
issue_pred_taken_in  input  1  branch prediction taken
rob_empty_out  output  1  no valid entries
rob_head_out  output  ROB_IDX_WIDTH  oldest entry index
rob_tail_out  output  ROB_IDX_WIDTH  next allocation index
alu_cdb_en_in  input  1  ALU result valid
alu_cdb_idx_in  input  ROB_IDX_WIDTH  target entry
alu_cdb_val_in  input  DATA_WIDTH  result value
alu_cdb_taken_in  input  1  actual branch outcome
alu_cdb_target_in  input  DATA_WIDTH  actual next PC for branches/JALR
lsb_cdb_en_in, lsb_cdb_idx_in, lsb_cdb_val_in  input  1/ROB_IDX_WIDTH/DATA_WIDTH  load result or store-address-ready
qry1_idx_in, qry2_idx_in  input  ROB_IDX_WIDTH  operand lookup
qry1_ready_out, qry2_ready_out  output  1  entry result available
qry1_val_out, qry2_val_out  output  DATA_WIDTH  entry result
commit_reg_en_out  output  1  write rd
commit_rd_out  output  `RegIdxWidth  committed rd
commit_val_out  output  DATA_WIDTH  committed value
commit_idx_out  output  ROB_IDX_WIDTH  committed entry (regfile clears its tag if equal)
commit_store_en_out  output  1  head store may write memory
flush_out  output  1  mispredict flush pulse
flush_pc_out  output  DATA_WIDTH  redirect PC

Behaviour:
- Reset: head = tail = 0, empty = 1; all entry busy/ready bits 0; every commit/flush output 0, flush_pc_out 0.
- Full is defined as head == tail && !empty. Issue allocates only when not full; an issue_en_in while full is ignored (defensive).
- Allocate: entry[tail] gets busy = 1, ready = 0, id, rd, pc, pred. Tail advances mod depth. Stores and branches allocate with rd forced to 0.
- Writeback: a CDB hit on a busy entry sets ready = 1 and stores val; the ALU additionally stores taken/target. ALU and LSB may write different entries in the same cycle. The same index on both buses is illegal; the ALU wins.
- Commit: at most one entry per cycle, when !empty && entry[head].ready. Outputs are registered and valid the cycle after the decision, one-cycle pulses.
  - Loads/ALU/JAL/JALR with rd != 0: commit_reg_en_out.
  - Stores: commit_store_en_out; the LSB performs the write and the ROB does not wait for it.
  - Branch/JALR with actual outcome != prediction, or JALR always: flush_out = 1, flush_pc_out = target, with the register write still performed for JALR.
  - Head advances, entry busy cleared.
- Flush: the cycle after flush_out, head = tail = 0, empty = 1, all busy/ready cleared. Issue/CDB inputs in the flush cycle are dropped.
- Empty update: set when head catches tail by commit with no simultaneous issue. Cleared by any issue. Simultaneous issue and commit keeps the count.
- Wrap: indices wrap naturally at 2**ROB_IDX_WIDTH.
- Query: combinational. ready/val come from the entry; an index of a non-busy entry returns ready = 0.
- rdy_in low: freezes pointers and entries, and suppresses commit pulses.
- Reset asserted mid-operation: returns to reset state immediately, no pulse outputs.

Optional Feature:
- ROB_CDB_BYPASS_EN defined: query outputs also match the same-cycle alu/lsb CDB (the ALU has priority), returning ready = 1 with the bus value.
- Not defined: the query sees only stored entry state, adding one cycle of latency to dependent issue.

Decomposition:
- Shared package/config.vh: instruction id constants (`SW, `LHU, `BEQ..`BGEU, `JAL, `JALR), `InstrIdWidth, `RegIdxWidth, `ROBIdxWidth, entry field widths, `TRUE/`FALSE/`ZERO.
- One natural sub-module: rob_query_port (single lookup plus optional bypass), instantiated twice.

Test Plan:
- Reset then issue ADDI rd = 5 to idx 0, ALU CDB idx 0 val 0x2A -> next cycle commit_reg_en_out = 1, rd = 5, val = 0x2A, idx = 0; rob_empty_out = 1 afterwards.
- Issue 16 entries with no writeback -> rob_empty_out = 0, head == tail == 0 (full); a 17th issue is ignored; complete entries out of order -> commits appear strictly 0..15, tail/head wrap to 0.
- SW at idx 3 reaches head with LSB CDB ready -> commit_store_en_out = 1, commit_reg_en_out = 0.
- BEQ predicted not-taken, ALU taken = 1 target 0x100 -> flush_out pulse with flush_pc_out = 0x100; next cycle empty = 1, head = tail = 0; the younger ready entry is never committed.
- Same-cycle issue and commit with 1 entry -> empty stays 0 and the count stays 1; query the freshly written idx with and without ROB_CDB_BYPASS_EN -> ready = 1 in the CDB cycle vs the following cycle.
- rst_in low mid-stream with 5 entries -> all outputs 0 and empty = 1 immediately; rdy_in low for 3 cycles with a ready head -> no commit until rdy_in returns.
